mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/load_format.sv | 25 ++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, access size
// decode and the access FSM state type.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC1 = 2'd1,
      ST_ACC2 = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Access size in bytes (1, 2 or 4); only meaningful for legal encodings.
   function automatic logic [2:0] fun3_size(input logic [2:0] fun3);
      case (fun3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Unsigned variants only exist for loads.
   function automatic logic fun3_illegal(input logic [2:0] fun3, input logic we);
      return (fun3 == 3'b011) || (fun3[2:1] == 2'b11) || (fun3[2] && we);
   endfunction

endpackage

// File: rtl/load_format.sv
// Combinational load formatter: aligns the two-word read image by the byte
// offset, truncates to the access size and sign- or zero-extends.
module load_format
   import lsu_pkg::*;
(
   input  logic [2:0]  fun3,
   input  logic [1:0]  offset,
   input  logic [63:0] image,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   always_comb begin
      shifted = 32'(image >> {offset, 3'b000});
      case (fun3)
         F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   rdata = {24'h0, shifted[7:0]};
         F3_HU:   rdata = {16'h0, shifted[15:0]};
         default: rdata = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a 32-bit word memory port;
// word-crossing accesses are split into two word accesses or rejected.
module mem_access_unit
   import lsu_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_fun3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  fun3_q, fun3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] rdata_q, rdata_d;

   logic [2:0]  size;
   logic [1:0]  offset;
   logic        crossing;
   logic [7:0]  mask;
   logic [63:0] image;
   logic [31:0] word_addr;
   logic [2:0]  req_size;
   logic        req_cross;
   logic        req_err;
   logic [63:0] fmt_image;
   logic [31:0] fmt_rdata;

   always_comb begin
      size      = fun3_size(fun3_q);
      offset    = addr_q[1:0];
      crossing  = ({2'b00, offset} + {1'b0, size}) > 4'd4;
      mask      = ((8'd1 << size) - 8'd1) << offset;
      image     = {32'h0, wdata_q} << {offset, 3'b000};
      word_addr = {addr_q[31:2], 2'b00};
      req_size  = fun3_size(req_fun3);
      req_cross = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
      req_err   = fun3_illegal(req_fun3, req_we) || (!ALLOW_MISALIGNED && req_cross);
   end

   // The upper word of a split load arrives in ACC2; the lower one was kept in lo_q.
   assign fmt_image = (state_q == ST_ACC2) ? {mem_rdata, lo_q} : {32'h0, mem_rdata};

   load_format u_load_format (
      .fun3   (fun3_q),
      .offset (offset),
      .image  (fmt_image),
      .rdata  (fmt_rdata)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      fun3_d  = fun3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      lo_d    = lo_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               fun3_d  = req_fun3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = req_err;
               rdata_d = 32'h0;
               state_d = req_err ? ST_DONE : ST_ACC1;
            end
         end
         ST_ACC1: begin
            lo_d = mem_rdata;
            if (crossing) begin
               state_d = ST_ACC2;
            end else begin
               state_d = ST_DONE;
               rdata_d = we_q ? 32'h0 : fmt_rdata;
            end
         end
         ST_ACC2: begin
            state_d = ST_DONE;
            rdata_d = we_q ? 32'h0 : fmt_rdata;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         fun3_q  <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         lo_q    <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         fun3_q  <= fun3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
      end
   end

   // Reset gates the strobes combinationally so an abandoned access never writes.
   always_comb begin
      req_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_DONE) && !reset;
      rsp_err   = rsp_valid && err_q;
      rsp_rdata = rdata_q;
      mem_req   = ((state_q == ST_ACC1) || (state_q == ST_ACC2)) && !reset;
      mem_we    = mem_req && we_q;
      mem_addr  = (state_q == ST_ACC2) ? (word_addr + 32'd4) : word_addr;
      mem_be    = 4'b0000;
      mem_wdata = 32'h0;
      if (mem_req) begin
         mem_be    = (state_q == ST_ACC2) ? mask[7:4] : mask[3:0];
         mem_wdata = (state_q == ST_ACC2) ? image[63:32] : image[31:0];
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word memory; a
// second instance covers the split-disabled configuration.
`timescale 1ns/1ps
module tb_mem_access_unit;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } acc_t;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  lat;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        nm_req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_fun3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = 32'h0;
   logic        nm_req_ready, nm_rsp_valid, nm_rsp_err, nm_mem_req, nm_mem_we;
   logic [31:0] nm_rsp_rdata, nm_mem_addr, nm_mem_wdata;
   logic [3:0]  nm_mem_be;
   logic [31:0] nm_mem_rdata = 32'h0;

   logic [31:0] mem [bit [31:0]];
   logic [31:0] wr_word;
   acc_t exp_acc_q[$], obs_acc_q[$];
   rsp_t exp_rsp_q[$], obs_rsp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   leak = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
      .clk(clk), .reset(reset), .req_valid(nm_req_valid), .req_ready(nm_req_ready),
      .req_we(req_we), .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(nm_rsp_valid), .rsp_err(nm_rsp_err), .rsp_rdata(nm_rsp_rdata),
      .mem_req(nm_mem_req), .mem_we(nm_mem_we), .mem_addr(nm_mem_addr), .mem_be(nm_mem_be),
      .mem_wdata(nm_mem_wdata), .mem_rdata(nm_mem_rdata)
   );

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic acc_t mk_acc(input logic [31:0] a, input logic [3:0] be,
                                   input logic we, input logic [31:0] wd);
      acc_t r;
      r.addr = a; r.be = be; r.we = we; r.wdata = wd;
      return r;
   endfunction

   function automatic rsp_t mk_rsp(input logic err, input logic [31:0] rdata, input logic [3:0] lat);
      rsp_t r;
      r.err = err; r.rdata = rdata; r.lat = lat;
      return r;
   endfunction

   // Read data is presented mid-cycle, well before the capturing edge.
   always @(negedge clk) begin
      mem_rdata    = rd(mem_addr);
      nm_mem_rdata = rd(nm_mem_addr);
   end

   always @(posedge clk) begin
      if (mem_req && mem_we) begin
         wr_word = rd(mem_addr);
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) wr_word[8*b +: 8] = mem_wdata[8*b +: 8];
         mem[mem_addr] = wr_word;
      end
   end

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
      rsp_t r;
      r = mk_rsp(1'b0, 32'h0, 4'hF);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_fun3 = f3; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (!mem_req && (mem_be != 4'b0000 || mem_we)) leak++;
         if (mem_req) obs_acc_q.push_back(mk_acc(mem_addr, mem_be, mem_we, mem_wdata));
         if (rsp_valid) begin
            r = mk_rsp(rsp_err, rsp_rdata, 4'(n));
            break;
         end
         @(negedge clk);
      end
      obs_rsp_q.push_back(r);
      $display("req we=%0b f3=%03b addr=%h wdata=%h -> err=%0b rdata=%h lat=%0d",
               we, f3, addr, wdata, r.err, r.rdata, r.lat);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input rsp_t exp);
      exp_rsp_q.push_back(exp);
      run_req(we, f3, addr, wdata);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be, rsp_rdata} !== {1'b1, 4'b0, 4'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state got rdy=%0b rv=%0b err=%0b mreq=%0b mwe=%0b be=%b rdata=%h want rdy=1 others 0",
                  req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be, rsp_rdata);
      end
      checks++;
      if ({nm_req_ready, nm_rsp_valid, nm_mem_req} !== 3'b100) begin
         errors++;
         $display("FAIL reset_state_nm got rdy=%0b rv=%0b mreq=%0b want 1 0 0", nm_req_ready, nm_rsp_valid, nm_mem_req);
      end
   endtask

   task automatic test_aligned();
      rsp_t e, o;
      acc_t ea, oa;
      exp_acc_q.push_back(mk_acc(32'h100, 4'b1111, 1'b1, 32'hDEADBEEF));
      issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, mk_rsp(1'b0, 32'h0, 4'd2));
      exp_acc_q.push_back(mk_acc(32'h100, 4'b1111, 1'b0, 32'h0));
      issue(1'b0, 3'b010, 32'h100, 32'h0, mk_rsp(1'b0, 32'hDEADBEEF, 4'd2));
      exp_acc_q.push_back(mk_acc(32'h200, 4'b0100, 1'b1, 32'h005A0000));
      issue(1'b1, 3'b000, 32'h202, 32'h0000005A, mk_rsp(1'b0, 32'h0, 4'd2));
      mem[32'h100] = 32'h000080FF;
      exp_acc_q.push_back(mk_acc(32'h100, 4'b0010, 1'b0, 32'h0));
      issue(1'b0, 3'b000, 32'h101, 32'h0, mk_rsp(1'b0, 32'hFFFFFF80, 4'd2));
      exp_acc_q.push_back(mk_acc(32'h100, 4'b0010, 1'b0, 32'h0));
      issue(1'b0, 3'b100, 32'h101, 32'h0, mk_rsp(1'b0, 32'h00000080, 4'd2));
      while (exp_rsp_q.size() != 0) begin
         e = exp_rsp_q.pop_front();
         if (obs_rsp_q.size() != 0) o = obs_rsp_q.pop_front(); else o = '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL aligned_rsp got err=%0b rdata=%h lat=%0d want err=%0b rdata=%h lat=%0d",
                     o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
         end
      end
      while (exp_acc_q.size() != 0) begin
         ea = exp_acc_q.pop_front();
         if (obs_acc_q.size() != 0) oa = obs_acc_q.pop_front(); else oa = '1;
         checks++;
         if (oa !== ea) begin
            errors++;
            $display("FAIL aligned_acc got addr=%h be=%b we=%0b wdata=%h want addr=%h be=%b we=%0b wdata=%h",
                     oa.addr, oa.be, oa.we, oa.wdata, ea.addr, ea.be, ea.we, ea.wdata);
         end
      end
      checks++;
      if (obs_acc_q.size() != 0 || rd(32'h200) !== 32'h005A0000) begin
         errors++;
         $display("FAIL aligned_extra got extra=%0d mem200=%h want 0 005a0000", obs_acc_q.size(), rd(32'h200));
      end
      obs_acc_q.delete(); obs_rsp_q.delete();
   endtask

   task automatic test_split();
      rsp_t e, o;
      acc_t ea, oa;
      mem[32'h100] = 32'h44332211;
      mem[32'h104] = 32'h88776655;
      exp_acc_q.push_back(mk_acc(32'h100, 4'b1000, 1'b0, 32'h0));
      exp_acc_q.push_back(mk_acc(32'h104, 4'b0111, 1'b0, 32'h0));
      issue(1'b0, 3'b010, 32'h103, 32'h0, mk_rsp(1'b0, 32'h77665544, 4'd3));
      mem[32'h0FC] = 32'h11111111;
      mem[32'h100] = 32'h22222222;
      exp_acc_q.push_back(mk_acc(32'h0FC, 4'b1000, 1'b1, 32'hCD000000));
      exp_acc_q.push_back(mk_acc(32'h100, 4'b0001, 1'b1, 32'h000000AB));
      issue(1'b1, 3'b001, 32'h0FF, 32'h0000ABCD, mk_rsp(1'b0, 32'h0, 4'd3));
      exp_acc_q.push_back(mk_acc(32'h0FC, 4'b1000, 1'b0, 32'h0));
      exp_acc_q.push_back(mk_acc(32'h100, 4'b0001, 1'b0, 32'h0));
      issue(1'b0, 3'b001, 32'h0FF, 32'h0, mk_rsp(1'b0, 32'hFFFFABCD, 4'd3));
      exp_acc_q.push_back(mk_acc(32'h0FC, 4'b1000, 1'b0, 32'h0));
      exp_acc_q.push_back(mk_acc(32'h100, 4'b0001, 1'b0, 32'h0));
      issue(1'b0, 3'b101, 32'h0FF, 32'h0, mk_rsp(1'b0, 32'h0000ABCD, 4'd3));
      exp_acc_q.push_back(mk_acc(32'hFFFFFFFC, 4'b1100, 1'b1, 32'h33440000));
      exp_acc_q.push_back(mk_acc(32'h00000000, 4'b0011, 1'b1, 32'h00001122));
      issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, mk_rsp(1'b0, 32'h0, 4'd3));
      while (exp_rsp_q.size() != 0) begin
         e = exp_rsp_q.pop_front();
         if (obs_rsp_q.size() != 0) o = obs_rsp_q.pop_front(); else o = '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL split_rsp got err=%0b rdata=%h lat=%0d want err=%0b rdata=%h lat=%0d",
                     o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
         end
      end
      while (exp_acc_q.size() != 0) begin
         ea = exp_acc_q.pop_front();
         if (obs_acc_q.size() != 0) oa = obs_acc_q.pop_front(); else oa = '1;
         checks++;
         if (oa !== ea) begin
            errors++;
            $display("FAIL split_acc got addr=%h be=%b we=%0b wdata=%h want addr=%h be=%b we=%0b wdata=%h",
                     oa.addr, oa.be, oa.we, oa.wdata, ea.addr, ea.be, ea.we, ea.wdata);
         end
      end
      checks++;
      if (obs_acc_q.size() != 0 || rd(32'h0FC) !== 32'hCD111111 || rd(32'h100) !== 32'h222222AB) begin
         errors++;
         $display("FAIL split_mem got extra=%0d fc=%h 100=%h want 0 cd111111 222222ab",
                  obs_acc_q.size(), rd(32'h0FC), rd(32'h100));
      end
      obs_acc_q.delete(); obs_rsp_q.delete();
   endtask

   task automatic test_illegal();
      rsp_t e, o;
      issue(1'b0, 3'b011, 32'h100, 32'h0, mk_rsp(1'b1, 32'h0, 4'd1));
      issue(1'b1, 3'b100, 32'h100, 32'h12345678, mk_rsp(1'b1, 32'h0, 4'd1));
      issue(1'b0, 3'b111, 32'h103, 32'h0, mk_rsp(1'b1, 32'h0, 4'd1));
      while (exp_rsp_q.size() != 0) begin
         e = exp_rsp_q.pop_front();
         if (obs_rsp_q.size() != 0) o = obs_rsp_q.pop_front(); else o = '1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL illegal_rsp got err=%0b rdata=%h lat=%0d want err=%0b rdata=%h lat=%0d",
                     o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
         end
      end
      checks++;
      if (obs_acc_q.size() != 0) begin
         errors++;
         $display("FAIL illegal_noacc got %0d accesses want 0", obs_acc_q.size());
      end
      obs_acc_q.delete(); obs_rsp_q.delete();
   endtask

   task automatic test_no_misaligned();
      logic [31:0] t_addr [2] = '{32'h102, 32'h102};
      logic [2:0]  t_f3   [2] = '{3'b010, 3'b001};
      rsp_t        t_exp  [2];
      rsp_t        o;
      int          nreq;
      t_exp[0] = mk_rsp(1'b1, 32'h0, 4'd1);
      t_exp[1] = mk_rsp(1'b0, 32'hFFFF9ABC, 4'd2);
      mem[32'h100] = 32'h9ABC0000;
      for (int i = 0; i < 2; i++) begin
         o = mk_rsp(1'b0, 32'h0, 4'hF);
         nreq = 0;
         @(negedge clk);
         nm_req_valid = 1'b1; req_we = 1'b0; req_fun3 = t_f3[i]; req_addr = t_addr[i]; req_wdata = 32'h0;
         @(negedge clk);
         nm_req_valid = 1'b0;
         for (int n = 1; n <= 6; n++) begin
            if (nm_mem_req) nreq++;
            if (nm_rsp_valid) begin
               o = mk_rsp(nm_rsp_err, nm_rsp_rdata, 4'(n));
               break;
            end
            @(negedge clk);
         end
         $display("nm req f3=%03b addr=%h -> err=%0b rdata=%h lat=%0d accesses=%0d",
                  t_f3[i], t_addr[i], o.err, o.rdata, o.lat, nreq);
         checks++;
         if (o !== t_exp[i] || nreq != int'(i)) begin
            errors++;
            $display("FAIL nomisalign_%0d got err=%0b rdata=%h lat=%0d acc=%0d want err=%0b rdata=%h lat=%0d acc=%0d",
                     i, o.err, o.rdata, o.lat, nreq, t_exp[i].err, t_exp[i].rdata, t_exp[i].lat, i);
         end
      end
   endtask

   task automatic test_reset_abort();
      int bad = 0;
      mem[32'h300] = 32'hAAAAAAAA;
      mem[32'h304] = 32'hBBBBBBBB;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_fun3 = 3'b010; req_addr = 32'h302; req_wdata = 32'h11223344;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({mem_req, mem_we, rsp_valid} !== 3'b000) begin
         errors++;
         $display("FAIL abort_gate got mreq=%0b mwe=%0b rv=%0b want 0 0 0", mem_req, mem_we, rsp_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL abort_idle got rdy=%0b rv=%0b want 1 0", req_ready, rsp_valid);
      end
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid || mem_req) bad++;
      end
      $display("abort split SW 0x302: mem300=%h mem304=%h late_activity=%0d", rd(32'h300), rd(32'h304), bad);
      checks++;
      if (bad != 0 || rd(32'h300) !== 32'h3344AAAA || rd(32'h304) !== 32'hBBBBBBBB) begin
         errors++;
         $display("FAIL abort_mem got late=%0d m300=%h m304=%h want 0 3344aaaa bbbbbbbb",
                  bad, rd(32'h300), rd(32'h304));
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] p_req = '0, p_rsp = '0, p_rdy = '0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_fun3 = 3'b000; req_addr = 32'h200; req_wdata = 32'h000000A5;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         p_req[n-1] = mem_req;
         p_rsp[n-1] = rsp_valid;
         p_rdy[n-1] = req_ready;
      end
      req_valid = 1'b0;
      $display("back_to_back mem_req=%b rsp_valid=%b req_ready=%b", p_req, p_rsp, p_rdy);
      checks++;
      if ({p_req, p_rsp, p_rdy} !== {5'b01001, 5'b10010, 5'b00100}) begin
         errors++;
         $display("FAIL back_to_back got req=%b rsp=%b rdy=%b want 01001 10010 00100", p_req, p_rsp, p_rdy);
      end
      checks++;
      if (leak != 0) begin
         errors++;
         $display("FAIL strobe_gating got %0d idle cycles with be/we set want 0", leak);
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_split();
      test_illegal();
      test_no_misaligned();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
